// File: rtl/dbuf_pkg.sv
// Shared types and constants for the double-buffered frame controller.
package dbuf_pkg;

  localparam int FRAME_PIX_DEF = 10000;

  localparam int R_LSB = 0;
  localparam int B_LSB = 8;
  localparam int G_LSB = 16;
  localparam int PIX_W = 24;

  typedef enum logic {
    FILL      = 1'b0,
    SWAP_WAIT = 1'b1
  } wstate_t;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] r;
  } pix_t;

  function automatic pix_t pix_join(input logic [7:0] r, input logic [7:0] g,
                                    input logic [7:0] b);
    logic [PIX_W-1:0] w;
    w = '0;
    w[R_LSB +: 8] = r;
    w[B_LSB +: 8] = b;
    w[G_LSB +: 8] = g;
    return pix_t'(w);
  endfunction

endpackage

// File: rtl/dbuf_addr_ctr.sv
// Wrapping address counter: addr is 0 when clr, else the held count; tc flags DEPTH-1.
// Latency: addr/tc combinational from clr; count updates on the clock edge.
// Backpressure: none, advances only when inc is asserted.
module dbuf_addr_ctr #(
  parameter int ADDR_W = 20,
  parameter int DEPTH  = 10000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              tc
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] cnt_q;

  always_comb begin
    addr = clr ? '0 : cnt_q;
    tc   = (addr == LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= tc ? '0 : addr + ADDR_W'(1);
    end else begin
      cnt_q <= addr;
    end
  end

endmodule

// File: rtl/dbuf_frame_ctrl.sv
// Ping-pong frame buffer controller; optional stats counters under DBUF_STATS_EN.
// Latency: buffer strobes same cycle as wr_valid/pix_req; pixel out 1 cycle after pix_req.
// Backpressure: wr_ready low while a complete back frame waits for rd_start.
module dbuf_frame_ctrl
  import dbuf_pkg::*;
#(
  parameter int FRAME_PIX = FRAME_PIX_DEF,
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_start,
  input  logic              pix_req,
  output logic              pix_valid,
  output logic [7:0]        pix_r,
  output logic [7:0]        pix_g,
  output logic [7:0]        pix_b,
  output logic              front_sel,
  output logic              swap_pending,
  output logic              b0_re,
  output logic              b0_we,
  output logic [ADDR_W-1:0] b0_addr,
  output logic [DATA_W-1:0] b0_wdata,
  input  logic [7:0]        b0_r,
  input  logic [7:0]        b0_g,
  input  logic [7:0]        b0_b,
  output logic              b1_re,
  output logic              b1_we,
  output logic [ADDR_W-1:0] b1_addr,
  output logic [DATA_W-1:0] b1_wdata,
  input  logic [7:0]        b1_r,
  input  logic [7:0]        b1_g,
  input  logic [7:0]        b1_b
`ifdef DBUF_STATS_EN
  ,
  output logic [15:0]       repeat_cnt,
  output logic [15:0]       drop_cnt
`endif
);

  wstate_t           state_q, state_d;
  logic              front_q, sel_q, pv_q;
  logic              accept, swap, front_eff, rd_act;
  logic              wr_tc;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [1:0]        buf_we, buf_re;
  logic [ADDR_W-1:0] addr_d [2];
  logic [ADDR_W-1:0] addr_q [2];
  logic [DATA_W-1:0] wdata_d [2];
  logic [DATA_W-1:0] wdata_q [2];
  pix_t              rd_pix;

  // Swap decision looks only at registered state, so a frame completing
  // in the rd_start cycle waits for the next start-of-frame.
  always_comb begin
    state_d      = state_q;
    wr_ready     = 1'b0;
    swap_pending = 1'b0;
    swap         = 1'b0;
    accept       = 1'b0;
    if (!reset) begin
      unique case (state_q)
        FILL: begin
          wr_ready = 1'b1;
          accept   = wr_valid;
          if (accept && wr_tc) state_d = SWAP_WAIT;
        end
        SWAP_WAIT: begin
          swap_pending = 1'b1;
          if (rd_start) begin
            swap    = 1'b1;
            state_d = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      front_q <= 1'b0;
      sel_q   <= 1'b0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      front_q <= front_eff;
      sel_q   <= front_eff;
      pv_q    <= rd_act;
    end
  end

  assign front_eff = front_q ^ swap;
  assign front_sel = front_eff & ~reset;
  assign rd_act    = pix_req & ~reset;

  dbuf_addr_ctr #(.ADDR_W(ADDR_W), .DEPTH(FRAME_PIX)) u_wr_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (accept),
    .addr  (wr_addr),
    .tc    (wr_tc)
  );

  dbuf_addr_ctr #(.ADDR_W(ADDR_W), .DEPTH(FRAME_PIX)) u_rd_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (rd_start),
    .inc   (rd_act),
    .addr  (rd_addr),
    .tc    ()
  );

  // Back buffer is written, front buffer read; an idle buffer keeps its last address.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      buf_we[i]  = accept && (front_q != 1'(i));
      buf_re[i]  = rd_act && (front_eff == 1'(i));
      addr_d[i]  = addr_q[i];
      wdata_d[i] = wdata_q[i];
      if (reset) begin
        addr_d[i]  = '0;
        wdata_d[i] = '0;
      end else if (buf_we[i]) begin
        addr_d[i]  = wr_addr;
        wdata_d[i] = wr_data;
      end else if (buf_re[i]) begin
        addr_d[i]  = rd_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
      end else begin
        addr_q[i]  <= addr_d[i];
        wdata_q[i] <= wdata_d[i];
      end
    end
  end

  assign b0_we    = buf_we[0];
  assign b0_re    = buf_re[0];
  assign b0_addr  = addr_d[0];
  assign b0_wdata = wdata_d[0];
  assign b1_we    = buf_we[1];
  assign b1_re    = buf_re[1];
  assign b1_addr  = addr_d[1];
  assign b1_wdata = wdata_d[1];

  assign pix_valid = pv_q & ~reset;

  always_comb begin
    rd_pix = sel_q ? pix_join(b1_r, b1_g, b1_b) : pix_join(b0_r, b0_g, b0_b);
    if (!pix_valid) rd_pix = '0;
  end

  assign pix_r = rd_pix.r;
  assign pix_g = rd_pix.g;
  assign pix_b = rd_pix.b;

`ifdef DBUF_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      repeat_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (rd_start && !swap && repeat_cnt != 16'hFFFF)
        repeat_cnt <= repeat_cnt + 16'd1;
      if (wr_valid && state_q == SWAP_WAIT && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule
